mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Load/store initiator that drives the single-port word-wide data RAM on behalf of the core's memory stage.
- The RAM reads combinationally, writes full words on the rising clock edge when write-enable is high, and ignores addr[1:0].
- This block converts byte, halfword and word loads and stores into RAM word accesses, using read-modify-write for sub-word stores.
- It sign- or zero-extends load data and flags misaligned or illegal requests without touching memory.

Parameters:
- ADDR_WIDTH, 32, width of request and memory addresses.
- DATA_WIDTH, 32, word width. Only 32 is supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-low.
- req_valid_i  input  1  core request valid.
- req_ready_o  output  1  block can accept a request (high only in IDLE).
- req_we_i  input  1  1 = store, 0 = load.
- req_size_i  input  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- req_unsigned_i  input  1  zero-extend loads when 1, sign-extend when 0.
- req_addr_i  input  ADDR_WIDTH  byte address.
- req_wdata_i  input  32  store data, right-aligned.
- resp_valid_o  output  1  response valid.
- resp_ready_i  input  1  core accepts the response.
- resp_rdata_o  output  32  extended load data; 0 for stores and errors.
- resp_err_o  output  1  misaligned or illegal-size request.
- mem_we_o  output  1  RAM write enable.
- mem_addr_o  output  ADDR_WIDTH  RAM address, always {addr[31:2],2'b00}.
- mem_wdata_o  output  32  RAM write word.
- mem_rdata_i  input  32  RAM read word, combinational from mem_addr_o.

Behaviour:
- States: IDLE, RD, WR, RESP.
- On the accept edge (IDLE, req_valid_i=1), register addr, size, we, unsigned and wdata.
- Request fields are ignored outside the accept cycle.
- Error check at accept: size=11, or halfword with addr[0]=1, or word with addr[1:0]!=0.
  - On error, go IDLE->RESP with err=1, rdata=0. No memory access; mem_we_o never asserts.
- Load: IDLE->RD->RESP.
  - In RD, mem_addr_o is the aligned address.
  - At the RD->RESP edge, capture mem_rdata_i and extract the lane:
    - byte lane selected by addr[1:0];
    - halfword lane selected by addr[1];
    - word passes through unchanged.
  - Extend to 32 bits per req_unsigned_i; req_unsigned_i is ignored for word loads.
- Word store: IDLE->WR->RESP.
  - In WR, mem_we_o=1 and mem_wdata_o=req_wdata for exactly one cycle.
- Sub-word store: IDLE->RD->WR->RESP.
  - Capture the old word at the RD->WR edge.
  - In WR, mem_wdata_o is the old word with only the addressed byte/halfword lane replaced by the low bits of wdata.
  - mem_we_o=1 for exactly one cycle.
- Latency, accept edge to resp_valid_o high:
  - error: 1 cycle
  - load / word store: 2 cycles
  - sub-word store: 3 cycles
- RESP: resp_valid_o=1. Hold resp_rdata_o and resp_err_o stable until resp_ready_i=1.
  - On the handshake edge, go RESP->IDLE.
  - A new request is accepted no earlier than the next cycle (no back-to-back overlap).
- Outside RD/WR: mem_addr_o=0, mem_wdata_o=0, mem_we_o=0.
- Outside RESP: resp_rdata_o=0, resp_err_o=0.
- Reset (rst=0 at a rising edge):
  - state->IDLE; all captured registers cleared.
  - While rst=0, all outputs are forced to 0 combinationally, including mem_we_o, req_ready_o and resp_valid_o.
  - Reset in WR therefore suppresses that write. Reset in RESP drops the response.
  - First accept is possible in the first cycle after rst returns high.
- Address bits above the RAM depth are passed unmodified; the RAM truncates them.

Test Plan:
- Word store then load: store 0xDEADBEEF @0x10 -> mem_we_o high for exactly 1 cycle with mem_addr_o=0x10; then load word @0x12 -> resp_err_o=1, no memory access; load word @0x10 -> resp_rdata_o=0xDEADBEEF, 2 cycles after accept.
- Byte store RMW: RAM[0x20]=0x11223344; store byte 0xAA @0x21 -> RD then WR; mem_wdata_o=0x1122AA44; load word @0x20 -> 0x1122AA44.
- Extension: RAM[0x30]=0x80F07F01.
  - signed byte @0x32 -> 0xFFFFFFF0; unsigned byte @0x32 -> 0x000000F0.
  - signed half @0x32 -> 0xFFFF80F0; unsigned half @0x30 -> 0x00007F01.
- Misalignment: half @0x05, word @0x06, size=11 @0x00 -> each gives resp_err_o=1, resp_rdata_o=0, 1-cycle latency, mem_we_o never high, RAM unchanged.
- Backpressure: load with resp_ready_i=0 for 4 cycles -> resp_valid_o and resp_rdata_o stable all 4 cycles; req_ready_o=0 throughout; IDLE one cycle after the handshake.
- Reset mid-op: sub-word store to 0x40, assert rst=0 during WR -> mem_we_o=0 that cycle, RAM[0x40] unchanged, all outputs 0; after release, req_ready_o=1.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator for a single-port, word-wide data RAM.
// Byte and halfword stores become a read-modify-write of the containing word.
// Loads are lane-extracted and then sign- or zero-extended.
// Misaligned or illegal-size requests answer with an error and never touch memory.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic                  we_q;
  logic                  uns_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  // Holds the extended load result, or the old word during a read-modify-write.
  logic [DATA_WIDTH-1:0] word_q;

  logic                  accept;
  logic                  req_err;
  logic [ADDR_WIDTH-1:0] aligned_addr;

  // Picks the addressed lane out of a RAM word and extends it to a full word.
  function automatic logic [DATA_WIDTH-1:0] extract_lane(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            offset,
    input logic [1:0]            size,
    input logic                  is_unsigned
  );
    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] result;
    lane_b = word[{offset, 3'b000} +: 8];
    lane_h = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: result = is_unsigned ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SIZE_HALF: result = is_unsigned ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default:   result = word;
    endcase
    return result;
  endfunction

  // Replaces only the addressed byte/halfword lane of the old word.
  function automatic logic [DATA_WIDTH-1:0] merge_lane(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] store_data,
    input logic [1:0]            offset,
    input logic [1:0]            size
  );
    logic [DATA_WIDTH-1:0] result;
    result = old_word;
    case (size)
      SIZE_BYTE: result[{offset, 3'b000} +: 8] = store_data[7:0];
      SIZE_HALF: begin
        if (offset[1]) result[31:16] = store_data[15:0];
        else           result[15:0]  = store_data[15:0];
      end
      default:   result = store_data;
    endcase
    return result;
  endfunction

  assign accept       = (state_q == IDLE) && req_valid_i;
  assign aligned_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  // Illegal size, or a halfword/word not aligned to its own size.
  assign req_err = (req_size_i == 2'b11) ||
                   ((req_size_i == SIZE_HALF) && req_addr_i[0]) ||
                   ((req_size_i == SIZE_WORD) && (req_addr_i[1:0] != 2'b00));

  // State register plus request capture and RAM word capture.
  // NOTE: sequential state uses <= so every register samples pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= req_addr_i;
        size_q  <= req_size_i;
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        err_q   <= req_err;
        wdata_q <= req_wdata_i;
      end
      if (state_q == RD) begin
        word_q <= we_q ? mem_rdata_i
                       : extract_lane(mem_rdata_i, addr_q[1:0], size_q, uns_q);
      end
    end
  end

  // Next-state selection.
  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (req_err)                                   state_d = RESP;
          else if (req_we_i && (req_size_i == SIZE_WORD)) state_d = WR;
          else                                           state_d = RD;
        end
      end
      RD:      state_d = we_q ? WR : RESP;
      WR:      state_d = RESP;
      RESP:    state_d = resp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is held at zero while reset is asserted.
  always_comb begin
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = '0;
    resp_err_o   = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (rst) begin
      case (state_q)
        IDLE: req_ready_o = 1'b1;
        RD:   mem_addr_o  = aligned_addr;
        WR: begin
          mem_addr_o  = aligned_addr;
          mem_we_o    = 1'b1;
          mem_wdata_o = (size_q == SIZE_WORD) ? wdata_q
                                              : merge_lane(word_q, wdata_q, addr_q[1:0], size_q);
        end
        RESP: begin
          resp_valid_o = 1'b1;
          resp_err_o   = err_q;
          resp_rdata_o = (we_q || err_q) ? '0 : word_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store traffic against a model RAM,
// with expectations computed from a word-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  // Environment RAM: 64 words, combinational read, write on the rising edge.
  logic [31:0] ram [0:63] = '{default: 32'h0};
  int          we_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  // Reference copy of memory contents, updated from the request rules only.
  logic [31:0] ref_mem [0:63];

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr[7:2]] <= mem_wdata;
      we_cnt             <= we_cnt + 1;
      last_waddr         <= mem_addr;
      last_wdata         <= mem_wdata;
    end
  end

  mem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .resp_valid_o   (resp_valid),
    .resp_ready_i   (resp_ready),
    .resp_rdata_o   (resp_rdata),
    .resp_err_o     (resp_err),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .mem_rdata_i    (mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request from IDLE, checks latency, response, memory traffic
  // and final RAM contents, holding the response for bp cycles before accepting it.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int bp, input string tag);
    logic        err;
    logic [31:0] old_w, new_w, exp_rdata, v, mask;
    int          off, idx, exp_lat, lat, we0, exp_writes;

    off = int'(addr % 4);
    idx = int'((addr % 256) / 4);
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && off != 0);
    old_w     = ref_mem[idx];
    new_w     = old_w;
    exp_rdata = 32'h0;
    if (err) begin
      exp_lat = 1;
    end else if (!we) begin
      exp_lat = 2;
      v = old_w >> (8 * off);
      if (size == 2'd0) begin
        v = v & 32'hFF;
        if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        v = v & 32'hFFFF;
        if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
      end
      exp_rdata = v;
    end else if (size == 2'd2) begin
      exp_lat = 2;
      new_w   = wdata;
    end else begin
      exp_lat = 3;
      mask    = (size == 2'd0) ? 32'hFF : 32'hFFFF;
      new_w   = (old_w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
    end
    ref_mem[idx] = new_w;
    exp_writes   = (we && !err) ? 1 : 0;

    check({tag, "/ready_idle"}, {31'd0, req_ready}, 32'd1);
    we0          = we_cnt;
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    tick();
    // Fields are don't-care after the accept edge; scramble them.
    req_valid    = 1'b0;
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;

    lat = 1;
    while (!resp_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/err"},     {31'd0, resp_err}, {31'd0, err});
    check({tag, "/rdata"},   resp_rdata, exp_rdata);

    for (int k = 0; k < bp; k++) begin
      tick();
      check({tag, "/hold_valid"}, {31'd0, resp_valid}, 32'd1);
      check({tag, "/hold_rdata"}, resp_rdata, exp_rdata);
      check({tag, "/hold_err"},   {31'd0, resp_err}, {31'd0, err});
      check({tag, "/hold_busy"},  {31'd0, req_ready}, 32'd0);
    end

    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    check({tag, "/idle_after"}, {31'd0, req_ready}, 32'd1);
    check({tag, "/valid_drop"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "/writes"},     32'(we_cnt - we0), 32'(exp_writes));
    if (exp_writes == 1) begin
      check({tag, "/waddr"}, last_waddr, addr & 32'hFFFF_FFFC);
      check({tag, "/wdata"}, last_wdata, new_w);
    end
    check({tag, "/ram"}, ram[idx], ref_mem[idx]);
  endtask

  initial begin
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    int          we0;

    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    rst          = 1'b0;
    req_valid    = 1'b0;
    req_we       = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    resp_ready   = 1'b0;

    tick();
    tick();
    check("rst/req_ready",  {31'd0, req_ready},  32'd0);
    check("rst/resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst/mem_we",     {31'd0, mem_we},     32'd0);
    check("rst/mem_addr",   mem_addr,            32'd0);
    check("rst/resp_rdata", resp_rdata,          32'd0);
    rst = 1'b1;
    #1;
    check("rst/ready_release", {31'd0, req_ready}, 32'd1);

    // Word store, misaligned word load, aligned word load.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, "st_w10");
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0,         0, "ld_w12_err");
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         0, "ld_w10");

    // Byte read-modify-write.
    do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 0, "st_w20");
    do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 0, "st_b21");
    do_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         0, "ld_w20");

    // Sign and zero extension.
    do_req(1'b1, 2'd2, 1'b0, 32'h30, 32'h80F0_7F01, 0, "st_w30");
    do_req(1'b0, 2'd0, 1'b0, 32'h32, 32'h0,         0, "ld_sb32");
    do_req(1'b0, 2'd0, 1'b1, 32'h32, 32'h0,         0, "ld_ub32");
    do_req(1'b0, 2'd1, 1'b0, 32'h32, 32'h0,         0, "ld_sh32");
    do_req(1'b0, 2'd1, 1'b1, 32'h30, 32'h0,         0, "ld_uh30");

    // Misaligned and illegal requests, including stores that must not write.
    do_req(1'b0, 2'd1, 1'b0, 32'h05, 32'h0,         0, "ld_h05_err");
    do_req(1'b1, 2'd2, 1'b0, 32'h06, 32'h1234_5678, 0, "st_w06_err");
    do_req(1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFF_FFFF, 0, "st_sz3_err");

    // Backpressure on a load.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4, "ld_bp");

    // Reset during the write cycle of a sub-word store.
    do_req(1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFE_F00D, 0, "st_w40");
    we0          = we_cnt;
    req_valid    = 1'b1;
    req_we       = 1'b1;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h41;
    req_wdata    = 32'h55;
    tick();
    req_valid = 1'b0;
    check("rmw/rd_addr", mem_addr, 32'h40);
    check("rmw/rd_we",   {31'd0, mem_we}, 32'd0);
    tick();
    check("rmw/wr_we",    {31'd0, mem_we}, 32'd1);
    check("rmw/wr_wdata", mem_wdata, 32'hCAFE_550D);
    rst = 1'b0;
    #1;
    check("rmw/rst_we",         {31'd0, mem_we},     32'd0);
    check("rmw/rst_addr",       mem_addr,            32'd0);
    check("rmw/rst_wdata",      mem_wdata,           32'd0);
    check("rmw/rst_ready",      {31'd0, req_ready},  32'd0);
    check("rmw/rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    check("rmw/ready_release", {31'd0, req_ready}, 32'd1);
    check("rmw/no_write",      32'(we_cnt - we0), 32'd0);
    check("rmw/ram_kept",      ram[16], 32'hCAFE_F00D);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 0, "ld_w40");

    // Random traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      r_addr = 32'($urandom_range(0, 255));
      r_size = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0 && r_size != 2'd3)
        r_addr = r_addr & ~((32'd1 << r_size) - 32'd1);
      do_req(1'($urandom), r_size, 1'($urandom), r_addr, $urandom,
             int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
